// File: rtl/systolic_array_sequencer_pkg.sv
// Shared defaults and FSM encoding for the systolic array sequencer.
package systolic_array_sequencer_pkg;

    localparam int DEF_N       = 2;
    localparam int DEF_WBITS   = 8;
    localparam int DEF_ABITS   = 16;
    localparam int DEF_ARR_LAT = 2;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/skew_line.sv
// Register delay line used for input skew, output de-skew and the tag pipeline.
// A DEPTH of 0 degenerates to a plain wire.
module skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_reset;
        assign unused_clk_reset = clk ^ reset;
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
            end else begin
                stage[0] <= d;
                for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Sequences weight load, skewed activation streaming and drain for one N x N
// weight-stationary systolic array, returning de-skewed, tag-qualified result rows.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  S_IDLE   | waiting for start; num_rows latched here
//  S_LOAD   | accepting N weight rows, each forwarded with arr_load
//  S_STREAM | accepting num_rows activation rows; bubbles on idle cycles
//  S_DRAIN  | zero rows injected for LAT cycles until last tag emerges
//  S_DONE   | single-cycle done pulse
module systolic_array_sequencer
    import systolic_array_sequencer_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int WBITS   = DEF_WBITS,
    parameter int ABITS   = DEF_ABITS,
    parameter int ARR_LAT = DEF_ARR_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_rows,
    output logic               busy,
    output logic               done,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [WBITS*N-1:0] w_data,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [WBITS*N-1:0] a_data,
    output logic               arr_load,
    output logic [WBITS*N-1:0] arr_weights_vector,
    output logic [ABITS*N-1:0] arr_sums_vector,
    input  logic [ABITS*N-1:0] arr_acc_vector,
    output logic               r_valid,
    output logic [ABITS*N-1:0] r_data
);

    localparam int LAT = ARR_LAT + N;

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rows_q, rows_d;
    logic               w_hs, a_hs;

    logic [WBITS*N-1:0] push_row;
    logic [WBITS*N-1:0] skewed_row;
    logic [ABITS*N-1:0] aligned_row;
    logic               tag_out;

    assign w_hs = w_valid & w_ready;
    assign a_hs = a_valid & a_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rows_q  <= rows_d;
        end
    end

    // Counters run down and compare against zero for their terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rows_d  = rows_q;
        busy    = 1'b1;
        done    = 1'b0;
        w_ready = 1'b0;
        a_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    rows_d = num_rows;
                    if (num_rows == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                        cnt_d   = CNT_W'(N - 1);
                    end
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                if (w_hs) begin
                    if (cnt_q == '0) begin
                        state_d = S_STREAM;
                        cnt_d   = rows_q - 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_STREAM: begin
                a_ready = 1'b1;
                if (a_hs) begin
                    if (cnt_q == '0) begin
                        state_d = S_DRAIN;
                        cnt_d   = CNT_W'(LAT - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Idle cycles outside STREAM push zero rows with tag 0, so drain needs no special case.
    assign push_row = a_hs ? a_data : '0;

    for (genvar i = 0; i < N; i++) begin : g_in_skew
        skew_line #(.WIDTH(WBITS), .DEPTH(i)) u_skew (
            .clk   (clk),
            .reset (reset),
            .d     (push_row[i*WBITS +: WBITS]),
            .q     (skewed_row[i*WBITS +: WBITS])
        );
    end

    for (genvar j = 0; j < N; j++) begin : g_out_deskew
        skew_line #(.WIDTH(ABITS), .DEPTH(N - 1 - j)) u_deskew (
            .clk   (clk),
            .reset (reset),
            .d     (arr_acc_vector[j*ABITS +: ABITS]),
            .q     (aligned_row[j*ABITS +: ABITS])
        );
    end

    // The output register below supplies the final stage of the LAT-cycle latency.
    skew_line #(.WIDTH(1), .DEPTH(LAT)) u_tag (
        .clk   (clk),
        .reset (reset),
        .d     (a_hs),
        .q     (tag_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arr_load           <= 1'b0;
            arr_weights_vector <= '0;
            r_valid            <= 1'b0;
            r_data             <= '0;
        end else begin
            arr_load           <= w_hs;
            arr_weights_vector <= w_hs ? w_data : skewed_row;
            r_valid            <= tag_out;
            r_data             <= tag_out ? aligned_row : '0;
        end
    end

    assign arr_sums_vector = '0;

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Bench for systolic_array_sequencer driving a behavioural 2x2 weight-stationary array;
// expected result rows go into a scoreboard queue and a monitor checks them as they emerge.
module tb_systolic_array_sequencer;

    localparam int N   = 2;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  num_rows;
    logic        busy, done;
    logic        w_valid, w_ready;
    logic [15:0] w_data;
    logic        a_valid, a_ready;
    logic [15:0] a_data;
    logic        arr_load;
    logic [15:0] arr_weights_vector;
    logic [31:0] arr_sums_vector;
    logic [31:0] arr_acc_vector;
    logic        r_valid;
    logic [31:0] r_data;

    systolic_array_sequencer #(
        .N(2), .WBITS(8), .ABITS(16), .ARR_LAT(2), .CNT_W(8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .num_rows           (num_rows),
        .busy               (busy),
        .done               (done),
        .w_valid            (w_valid),
        .w_ready            (w_ready),
        .w_data             (w_data),
        .a_valid            (a_valid),
        .a_ready            (a_ready),
        .a_data             (a_data),
        .arr_load           (arr_load),
        .arr_weights_vector (arr_weights_vector),
        .arr_sums_vector    (arr_sums_vector),
        .arr_acc_vector     (arr_acc_vector),
        .r_valid            (r_valid),
        .r_data             (r_data)
    );

    always #5 clk = ~clk;

    // Array: activations flow right along rows, partial sums flow down columns.
    // Loading shifts weight rows downward, so the first row loaded ends in the bottom row.
    logic [15:0] arr_w   [2][2];
    logic [7:0]  arr_act [2][2];
    logic [15:0] arr_ps  [2][2];

    function automatic logic [7:0] act_in(int r, int c);
        if (c == 0) return arr_weights_vector[r*8 +: 8];
        return arr_act[r][c-1];
    endfunction

    function automatic logic [15:0] sum_in(int r, int c);
        if (r == 0) return arr_sums_vector[c*16 +: 16];
        return arr_ps[r-1][c];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    arr_w[r][c]   <= '0;
                    arr_act[r][c] <= '0;
                    arr_ps[r][c]  <= '0;
                end
        end else begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    arr_act[r][c] <= act_in(r, c);
                    arr_ps[r][c]  <= sum_in(r, c) + 16'(act_in(r, c)) * arr_w[r][c];
                end
            if (arr_load)
                for (int c = 0; c < N; c++) begin
                    arr_w[0][c] <= {8'd0, arr_weights_vector[c*8 +: 8]};
                    arr_w[1][c] <= arr_w[0][c];
                end
        end
    end

    assign arr_acc_vector = {arr_ps[1][1], arr_ps[1][0]};

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q [$];
    exp_t exp_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   load_cnt = 0;
    int   rv_cnt = 0;
    int   last_k = 0;

    logic [15:0] wrow [2];
    logic [15:0] arow [2];
    logic [31:0] rexp [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each presented result row.
    always @(negedge clk) begin
        if (!reset) begin
            if (arr_load) load_cnt++;
            if (r_valid) begin
                rv_cnt++;
                check("r_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("r_data", r_data, exp_e.data);
                    check("r_cycle", cyc, exp_e.cyc);
                end
            end
        end
    end

    task automatic send_w(input logic [15:0] d);
        int b;
        b = 0;
        w_valid = 1'b1;
        w_data  = d;
        while (!w_ready && b < 20) begin @(negedge clk); b++; end
        check("w_ready_wait", {31'd0, w_ready}, 32'd1);
        @(negedge clk);
        w_valid = 1'b0;
        w_data  = '0;
    endtask

    task automatic send_a(input logic [15:0] d, input logic [31:0] want);
        int b;
        b = 0;
        a_valid = 1'b1;
        a_data  = d;
        while (!a_ready && b < 20) begin @(negedge clk); b++; end
        check("a_ready_wait", {31'd0, a_ready}, 32'd1);
        if (a_ready) exp_q.push_back('{data: want, cyc: cyc + 1 + LAT});
        @(negedge clk);
        a_valid = 1'b0;
        a_data  = '0;
        last_k  = cyc;
    endtask

    task automatic run_job(input int n_rows, input int w_gap, input int a_gap, input bit poke);
        int b;
        load_cnt = 0;
        rv_cnt   = 0;
        start    = 1'b1;
        num_rows = 8'(n_rows);
        @(negedge clk);
        start = 1'b0;
        send_w(wrow[0]);
        if (poke) begin start = 1'b1; num_rows = 8'd5; end
        repeat (w_gap) @(negedge clk);
        start    = 1'b0;
        num_rows = 8'(n_rows);
        send_w(wrow[1]);
        for (int r = 0; r < n_rows; r++) begin
            send_a(arow[r], rexp[r]);
            if (r < n_rows - 1) repeat (a_gap) @(negedge clk);
        end
        b = 0;
        while (!done && b < 30) begin @(negedge clk); b++; end
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_cycle", cyc, last_k + LAT);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("load_count", load_cnt, 32'd2);
        check("rv_count", rv_cnt, n_rows);
        check("sb_empty", exp_q.size(), 32'd0);
    endtask

    task automatic set_ones_job();
        wrow[0] = {8'd1, 8'd1};
        wrow[1] = {8'd1, 8'd1};
        arow[0] = {8'd3, 8'd2};
        arow[1] = {8'd1, 8'd7};
        rexp[0] = {16'd5, 16'd5};
        rexp[1] = {16'd8, 16'd8};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        num_rows = '0;
        w_valid  = 1'b0;
        w_data   = '0;
        a_valid  = 1'b0;
        a_data   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_w_ready", {31'd0, w_ready}, 32'd0);
        check("idle_sums", arr_sums_vector, 32'd0);

        // Mid-cycle reset while a weight row is being presented to the array
        set_ones_job();
        start    = 1'b1;
        num_rows = 8'd2;
        @(negedge clk);
        start = 1'b0;
        send_w(wrow[0]);
        check("pre_rst_load", {31'd0, arr_load}, 32'd1);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_w_ready", {31'd0, w_ready}, 32'd0);
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_arr_load", {31'd0, arr_load}, 32'd0);
        check("rst_r_valid", {31'd0, r_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // All-ones job, back to back
        run_job(2, 0, 0, 1'b0);
        // Weight stall between rows
        run_job(2, 2, 0, 1'b0);
        // Activation bubbles between rows
        run_job(2, 0, 3, 1'b0);

        // Reset during STREAM after one row accepted
        load_cnt = 0;
        start    = 1'b1;
        num_rows = 8'd2;
        @(negedge clk);
        start = 1'b0;
        send_w(wrow[0]);
        send_w(wrow[1]);
        send_a(arow[0], rexp[0]);
        #1 reset = 1'b1;
        exp_q.delete();
        rv_cnt = 0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_rvalid", rv_cnt, 32'd0);
        run_job(2, 0, 0, 1'b0);

        // Zero-row job
        load_cnt = 0;
        rv_cnt   = 0;
        start    = 1'b1;
        num_rows = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("zero_done_end", {31'd0, done}, 32'd0);
        check("zero_idle", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("zero_no_load", load_cnt, 32'd0);
        check("zero_no_rvalid", rv_cnt, 32'd0);

        // start held while busy must not disturb the running job
        run_job(2, 2, 0, 1'b1);

        // Distinct weights: W row0 = {3,4}, row1 = {1,2} after loading
        wrow[0] = {8'd2, 8'd1};
        wrow[1] = {8'd4, 8'd3};
        arow[0] = {8'd3, 8'd2};
        arow[1] = {8'd1, 8'd5};
        rexp[0] = {16'd14, 16'd9};
        rexp[1] = {16'd22, 16'd16};
        run_job(2, 1, 1, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
